// File: rtl/exec_wb_unit.sv
// exec_wb_unit: execute/write-back stage in front of reg_bank.
// Issues source addresses to the bank, captures operands (with a one-entry
// bypass from the write port), computes an ALU result or a 32-cycle
// shift-add multiply, and drives the bank write port for one cycle.
// Ports:
//   clk, reset_n                 clock, async active-low reset
//   in_valid/in_ready            instruction handshake
//   in_op, in_sr1, in_sr2, in_dr instruction fields
//   sr1, sr2                     bank read addresses (combinational)
//   read_data_1, read_data_2     bank read data
//   write, dr, write_data        registered bank write port
//   busy                         multiply in progress
module exec_wb_unit (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [2:0]  in_op,
    input  logic [4:0]  in_sr1,
    input  logic [4:0]  in_sr2,
    input  logic [4:0]  in_dr,
    output logic [4:0]  sr1,
    output logic [4:0]  sr2,
    input  logic [31:0] read_data_1,
    input  logic [31:0] read_data_2,
    output logic        write,
    output logic [4:0]  dr,
    output logic [31:0] write_data,
    output logic        busy
);

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned CW = 5;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WB   = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_SLT = 3'd5;
    localparam logic [2:0] OP_SLL = 3'd6;
    localparam logic [2:0] OP_MUL = 3'd7;

    logic [1:0]    state_q, state_d;
    logic          write_q, write_d;
    logic [AW-1:0] dr_q, dr_d;
    logic [DW-1:0] wd_q, wd_d;
    logic          busy_q, busy_d;
    logic [DW-1:0] acc_q, acc_d;
    logic [DW-1:0] mcand_q, mcand_d;
    logic [DW-1:0] mplier_q, mplier_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] mdr_q, mdr_d;

    logic [DW-1:0] op1, op2, alu_res, mul_sum;
    logic          accept;

    assign sr1      = in_sr1;
    assign sr2      = in_sr2;
    assign in_ready = (state_q != S_MUL);
    assign accept   = in_valid && in_ready;

    assign write      = write_q;
    assign dr         = dr_q;
    assign write_data = wd_q;
    assign busy       = busy_q;

    // The bank commits on the same edge we capture, so forward the pending write.
    assign op1 = (write_q && dr_q == in_sr1) ? wd_q : read_data_1;
    assign op2 = (write_q && dr_q == in_sr2) ? wd_q : read_data_2;

    // Single-cycle ALU.
    always_comb begin
        alu_res = '0;
        case (in_op)
            OP_ADD:  alu_res = op1 + op2;
            OP_SUB:  alu_res = op1 - op2;
            OP_AND:  alu_res = op1 & op2;
            OP_OR:   alu_res = op1 | op2;
            OP_XOR:  alu_res = op1 ^ op2;
            OP_SLT:  alu_res = ($signed(op1) < $signed(op2)) ? DW'(1) : DW'(0);
            OP_SLL:  alu_res = op1 << op2[4:0];
            default: alu_res = '0;
        endcase
    end

    // One shift-add step of the multiply.
    assign mul_sum = acc_q + (mplier_q[0] ? mcand_q : DW'(0));

    // Next-state and output logic.
    always_comb begin
        state_d  = state_q;
        write_d  = 1'b0;
        dr_d     = dr_q;
        wd_d     = wd_q;
        busy_d   = 1'b0;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        mdr_d    = mdr_q;
        case (state_q)
            S_IDLE, S_WB: begin
                state_d = S_IDLE;
                if (accept) begin
                    if (in_op == OP_MUL) begin
                        acc_d    = '0;
                        mcand_d  = op1;
                        mplier_d = op2;
                        cnt_d    = '0;
                        mdr_d    = in_dr;
                        busy_d   = 1'b1;
                        state_d  = S_MUL;
                    end else begin
                        write_d = 1'b1;
                        dr_d    = in_dr;
                        wd_d    = alu_res;
                        state_d = S_WB;
                    end
                end
            end
            S_MUL: begin
                acc_d    = mul_sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                busy_d   = 1'b1;
                if (cnt_q == CW'(31)) begin
                    write_d = 1'b1;
                    dr_d    = mdr_q;
                    wd_d    = mul_sum;
                    busy_d  = 1'b0;
                    state_d = S_WB;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            write_q  <= 1'b0;
            dr_q     <= '0;
            wd_q     <= '0;
            busy_q   <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            mdr_q    <= '0;
        end else begin
            state_q  <= state_d;
            write_q  <= write_d;
            dr_q     <= dr_d;
            wd_q     <= wd_d;
            busy_q   <= busy_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            mdr_q    <= mdr_d;
        end
    end

endmodule

// File: tb/tb_exec_wb_unit.sv
// Testbench for exec_wb_unit: bench-side register bank, architectural model
// of in-order execution, per-cycle compare plus directed literal checks.
module tb_exec_wb_unit;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [4:0]  in_sr1, in_sr2, in_dr;
    logic [4:0]  sr1, sr2;
    logic [31:0] read_data_1, read_data_2;
    logic        write;
    logic [4:0]  dr;
    logic [31:0] write_data;
    logic        busy;

    int total = 0;
    int bad   = 0;

    exec_wb_unit dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_sr1(in_sr1), .in_sr2(in_sr2), .in_dr(in_dr),
        .sr1(sr1), .sr2(sr2),
        .read_data_1(read_data_1), .read_data_2(read_data_2),
        .write(write), .dr(dr), .write_data(write_data), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int i);
        case (i)
            0: return 32'd0;
            1: return 32'd5;
            2: return 32'd7;
            6: return 32'hFFFF_FFFF;
            7: return 32'd1;
            8: return 32'd3;
            9: return 32'd35;
            default: return 32'(i) * 32'h0101_0101 + 32'h100;
        endcase
    endfunction

    // Register bank behaviour: combinational read, commit on write.
    logic [31:0] bank [32];
    bit bank_ready = 1'b0;
    always @(posedge clk) begin
        if (!bank_ready) begin
            for (int i = 0; i < 32; i++) bank[i] <= init_val(i);
            bank_ready <= 1'b1;
        end else if (write) begin
            bank[dr] <= write_data;
        end
    end
    assign read_data_1 = bank[sr1];
    assign read_data_2 = bank[sr2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_alu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            3'd6: return a << b[4:0];
            default: return a * b;
        endcase
    endfunction

    // Architectural model: results take effect in program order; a write
    // visible in a cycle is committed at the following edge, before any
    // instruction accepted at that edge reads its operands.
    logic [31:0] arch [32];
    bit          arch_init = 1'b0;
    logic        exp_write = 1'b0;
    logic [4:0]  exp_dr    = '0;
    logic [31:0] exp_wd    = '0;
    logic        exp_busy  = 1'b0;
    logic        exp_ready = 1'b1;
    int          mul_left  = 0;
    logic [31:0] mul_val   = '0;
    logic [4:0]  mul_dr    = '0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            if (!arch_init) begin
                for (int i = 0; i < 32; i++) arch[i] = init_val(i);
                arch_init = 1'b1;
            end
            exp_write = 1'b0;
            exp_dr    = '0;
            exp_wd    = '0;
            exp_busy  = 1'b0;
            exp_ready = 1'b1;
            mul_left  = 0;
        end else begin
            if (exp_write) arch[exp_dr] = exp_wd;
            exp_write = 1'b0;
            if (mul_left > 0) begin
                mul_left--;
                if (mul_left == 0) begin
                    exp_write = 1'b1;
                    exp_dr    = mul_dr;
                    exp_wd    = mul_val;
                    exp_busy  = 1'b0;
                    exp_ready = 1'b1;
                end
            end else if (in_valid && exp_ready) begin
                if (in_op == 3'd7) begin
                    mul_val   = arch[in_sr1] * arch[in_sr2];
                    mul_dr    = in_dr;
                    mul_left  = 32;
                    exp_busy  = 1'b1;
                    exp_ready = 1'b0;
                end else begin
                    exp_write = 1'b1;
                    exp_dr    = in_dr;
                    exp_wd    = exp_alu(in_op, arch[in_sr1], arch[in_sr2]);
                end
            end
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (reset_n === 1'b1 && bank_ready) begin
            check("cyc_write",    32'(write),    32'(exp_write));
            check("cyc_dr",       32'(dr),       32'(exp_dr));
            check("cyc_wdata",    write_data,    exp_wd);
            check("cyc_busy",     32'(busy),     32'(exp_busy));
            check("cyc_in_ready", 32'(in_ready), 32'(exp_ready));
        end
    end

    // Present an instruction at a negedge; return at the negedge after accept.
    task automatic issue(input logic [2:0] op, input logic [4:0] a, input logic [4:0] b, input logic [4:0] d);
        bit got;
        got = 1'b0;
        in_valid = 1'b1;
        in_op = op; in_sr1 = a; in_sr2 = b; in_dr = d;
        for (int n = 0; n < 100 && !got; n++) begin
            got = in_ready;
            @(posedge clk);
            if (!got) @(negedge clk);
        end
        if (!got) check("accept_timeout", 32'd0, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        int k;
        reset_n = 1'b0;
        in_valid = 1'b0;
        in_op = '0; in_sr1 = '0; in_sr2 = '0; in_dr = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_write",    32'(write),    32'd0);
        check("rst_dr",       32'(dr),       32'd0);
        check("rst_wdata",    write_data,    32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        reset_n = 1'b1;

        // ADD r3 = r1 + r2
        issue(3'd0, 5'd1, 5'd2, 5'd3);
        check("add_write", 32'(write), 32'd1);
        check("add_dr",    32'(dr),    32'd3);
        check("add_wdata", write_data, 32'd12);
        @(negedge clk);
        check("add_write_drop", 32'(write), 32'd0);

        // r3 = 10 committed, then r3 = 12 followed by dependent SUB.
        issue(3'd0, 5'd1, 5'd1, 5'd3);
        @(negedge clk);
        issue(3'd0, 5'd1, 5'd2, 5'd3);
        issue(3'd1, 5'd3, 5'd1, 5'd4);
        check("bypass_sub", write_data, 32'd7);

        // Both operands bypassed from the same destination.
        issue(3'd0, 5'd1, 5'd2, 5'd10);
        issue(3'd0, 5'd10, 5'd10, 5'd11);
        check("bypass_both", write_data, 32'd24);

        issue(3'd1, 5'd0, 5'd7, 5'd12);
        check("sub_wrap", write_data, 32'hFFFF_FFFF);
        issue(3'd5, 5'd6, 5'd7, 5'd13);
        check("slt_neg_pos", write_data, 32'd1);
        issue(3'd5, 5'd7, 5'd6, 5'd14);
        check("slt_pos_neg", write_data, 32'd0);
        issue(3'd6, 5'd7, 5'd9, 5'd15);
        check("sll_by_35", write_data, 32'd8);
        issue(3'd2, 5'd6, 5'd9, 5'd19);
        issue(3'd3, 5'd1, 5'd2, 5'd20);
        issue(3'd4, 5'd19, 5'd20, 5'd21);
        issue(3'd0, 5'd21, 5'd15, 5'd22);
        @(negedge clk);

        // MUL r5 = 0xFFFFFFFF * 3 with a dependent ADD held upstream.
        issue(3'd7, 5'd6, 5'd8, 5'd5);
        in_valid = 1'b1;
        in_op = 3'd0; in_sr1 = 5'd5; in_sr2 = 5'd1; in_dr = 5'd16;
        k = 0;
        while (!in_ready && k < 40) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        check("mul_stall_cycles", 32'(k),     32'd32);
        check("mul_write",        32'(write), 32'd1);
        check("mul_dr",           32'(dr),    32'd5);
        check("mul_wdata",        write_data, 32'hFFFF_FFFD);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("post_mul_add_dr",    32'(dr),    32'd16);
        check("post_mul_add_wdata", write_data, 32'd2);
        @(negedge clk);

        // Reset in the middle of a multiply.
        issue(3'd7, 5'd6, 5'd8, 5'd17);
        repeat (10) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_write", 32'(write),    32'd0);
        check("midrst_busy",  32'(busy),     32'd0);
        check("midrst_wdata", write_data,    32'd0);
        check("midrst_dr",    32'(dr),       32'd0);
        check("midrst_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (40) @(negedge clk);
        check("midrst_no_commit", bank[17], init_val(17));
        issue(3'd0, 5'd1, 5'd2, 5'd18);
        check("post_rst_add_dr",    32'(dr),    32'd18);
        check("post_rst_add_wdata", write_data, 32'd12);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exec_wb_unit.md
# exec_wb_unit

Execute/write-back stage that sits directly in front of `reg_bank`. It issues source register addresses to the bank and captures the two read operands. It computes an ALU or multi-cycle multiply result, then drives the bank's write port (`write`, `dr`, `write_data`) for exactly one cycle per instruction. A one-entry bypass lets a dependent instruction issue in the same cycle the bank is being written.

## Interface
- No parameters. Data width is fixed at 32 and the register address width at 5, matching `reg_bank`.
- `clk`  in  1  rising-edge clock, shared with `reg_bank`.
- `reset_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  an instruction is presented on `in_op`/`in_sr1`/`in_sr2`/`in_dr`.
- `in_ready`  out  1  the stage accepts an instruction this cycle; transfer occurs when `in_valid && in_ready`.
- `in_op`  in  3  operation select:
  - 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR.
  - 101 SLT (signed), 110 SLL, 111 MUL.
- `in_sr1`, `in_sr2`, `in_dr`  in  5  source and destination register numbers.
- `sr1`, `sr2`  out  5  connect to the bank read addresses; combinational copies of `in_sr1`/`in_sr2`.
- `read_data_1`, `read_data_2`  in  32  bank read data; combinational from `sr1`/`sr2`.
- `write`  out  1  bank write enable, registered.
- `dr`  out  5  bank write address, registered.
- `write_data`  out  32  bank write data, registered.
- `busy`  out  1  high while a MUL is iterating.

## Operation
- States:
  - IDLE: nothing pending.
  - WB: result on the write port.
  - MUL: iterating a multiply.
- `in_ready` is 1 in IDLE and WB, and 0 in MUL. It is a function of state only.
- Operand capture on accept, per operand:
  - If `write && dr == in_srX`, capture `write_data` (bypass).
  - Otherwise capture `read_data_X`.
  - Register 0 is not special; the bank does not hardwire it.
- Single-cycle ops (ADD..SLL): result, `in_dr` and `write=1` are registered at the accept edge, and the state becomes WB.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^32.
  - AND/OR/XOR are bitwise.
  - SLT yields 32'd1 if op1 < op2 as signed two's complement, else 32'd0.
  - SLL shifts op1 left by op2[4:0], zero fill.
- MUL:
  - Accept loads three registers: accumulator = 0, multiplicand = op1, multiplier = op2, with iteration count 0.
  - State becomes MUL, `busy=1`, and `write` is cleared.
  - Each MUL cycle: if multiplier[0], accumulator += multiplicand (mod 2^32). Then multiplicand <<= 1, multiplier >>= 1, count++.
  - On the edge completing iteration 31: `write_data` = accumulator, `dr` = latched `in_dr`, `write=1`, `busy=0`, state becomes WB.
  - The result is the low 32 bits of the product, which is identical for signed and unsigned operands.
- WB behaviour:
  - `write` is high for exactly one cycle.
  - If an instruction is accepted in WB, the next edge starts it: a new WB for a single-cycle op, or MUL.
  - With no accept, the next edge returns to IDLE with `write=0`.
  - `dr`/`write_data` hold their last values when `write=0`.
- An instruction is never dropped or duplicated. In MUL, `in_valid` is ignored and the upstream holds its instruction.

## Timing
- Reset (asynchronous, effective immediately while `reset_n=0`):
  - State = IDLE.
  - `write=0`, `dr=0`, `write_data=0`, `busy=0`.
  - `in_ready=1`, and the MUL registers are cleared.
- Reset mid-MUL aborts the multiply with no write. Reset during WB deasserts `write` immediately.
- Release of `reset_n` is synchronised by the system; the first accept may occur on the first rising edge after release.
- Latency, with accept on edge E0:
  - ADD..SLL: `write=1` in the cycle after E0, and the bank commits at E1.
  - MUL: `busy` is high from E0 to E32, `write=1` in the cycle after E32, and the bank commits at E33.
- Throughput:
  - Single-cycle ops: one per cycle, back to back.
  - MUL: one per 33 cycles; `in_ready` is low for the 32 MUL cycles.
- Bypass timing: the bank commits and the stage captures on the same edge. The bypass is therefore mandatory for a dependent instruction issued while `write=1`. It applies to both operands independently, including `in_sr1 == in_sr2 == dr`.

## Test plan
- Reset, then ADD with r1=5, r2=7, dr=3 → `write=1` one cycle after accept, `dr=3`, `write_data=12`; `write=0` on the following cycle.
- Back-to-back dependent pair:
  - First: ADD r3 = r1+r2 (5+7).
  - Next cycle: SUB r4 = r3−r1.
  - Required: the second `write_data` is 7 via the bypass, not the stale r3 value.
- SUB 0−1 → 0xFFFFFFFF; SLT (−1, 1) → 1; SLT (1, −1) → 0; SLL 1 by 35 → 0x00000008 (shift amount taken from op2[4:0] = 3).
- MUL 0xFFFFFFFF × 3, dr=5:
  - `busy=1` and `in_ready=0` for 32 cycles.
  - `write=1`, `write_data=0xFFFFFFFD` exactly 33 cycles after accept.
  - An ADD held on `in_valid` throughout is accepted only in the WB cycle.
- Reset asserted 10 cycles into a MUL → `write`, `busy`, `write_data` and `dr` go to 0 immediately; no write occurs after release; a new ADD then completes normally.
